// File: rtl/hpu_pkg.sv
// Shared types and defaults for the hypervector processing path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: DIM/CW defaults, hv_t vector type, bundler state enum, 16-bit saturating increment.
package hpu_pkg;

  localparam int DIM = 1023;  // MSB index; vectors are DIM+1 bits
  localparam int CW  = 8;     // per-lane counter width (two's complement)

  typedef logic [DIM:0] hv_t;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Vector count saturates rather than wrapping so an overlong bundle still reports "many".
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hv_lane_counter.sv
// One bit lane of the bundler: signed saturating up/down vote counter.
// Latency: sign/zero of the post-update value is combinational; counter updates on the edge.
// Backpressure: none; updates whenever en=1, clr has priority.
// Ports: clk, rst_n (async low), clr (sync clear), en (count this cycle), up (1:+1, 0:-1),
//        nxt_pos / nxt_neg: sign of the value the counter would take if en were applied.
module hv_lane_counter #(
  parameter int CW = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic up,
  output logic nxt_pos,
  output logic nxt_neg
);

  localparam logic [CW-1:0] CMAX = {1'b0, {(CW-1){1'b1}}};
  localparam logic [CW-1:0] CMIN = {1'b1, {(CW-1){1'b0}}};
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt;
  logic [CW-1:0] upd;

  // Saturating step: the extremes hold instead of wrapping across the sign boundary.
  always_comb begin
    upd = cnt;
    if (up) begin
      if (cnt != CMAX) upd = cnt + ONE;
    end else begin
      if (cnt != CMIN) upd = cnt - ONE;
    end
  end

  // The threshold for the closing vector must include that vector's own vote, so the
  // sign is taken from the updated value, not the stored one.
  assign nxt_neg = upd[CW-1];
  assign nxt_pos = !upd[CW-1] && (|upd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= upd;
    end
  end

endmodule

// File: rtl/hv_bundle_counter.sv
// Bundles a stream of hypervectors by per-bit majority vote and offers the result on valid/ready.
// Latency: result valid one cycle after the store&last edge.
// Backpressure: result held until out_ready; stores arriving meanwhile are dropped and flag overrun.
// Ports: clk, rst_n (async low), run (0 = sync clear), store/last/core_result (input stream),
//        tie_rand (tie-break for zero lanes), out_ready/out_valid/out_data/out_count (result),
//        overrun (sticky loss flag).
module hv_bundle_counter
  import hpu_pkg::*;
#(
  parameter int DIM = hpu_pkg::DIM,
  parameter int CW  = hpu_pkg::CW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         store,
  input  logic         last,
  input  logic [DIM:0] core_result,
  input  logic [DIM:0] tie_rand,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [DIM:0] out_data,
  output logic [15:0]  out_count,
  output logic         overrun
);

  state_t       state;
  logic [15:0]  n;
  logic         accept;
  logic         close;
  logic         lane_clr;
  logic [DIM:0] lane_pos;
  logic [DIM:0] lane_neg;
  logic [DIM:0] thr;

  assign accept   = (state == ACCUM) && store;
  assign close    = accept && last;
  // Closing a bundle restarts the lanes in the same edge that captures the threshold.
  assign lane_clr = !run || close;

  for (genvar i = 0; i <= DIM; i++) begin : g_lane
    hv_lane_counter #(.CW(CW)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (lane_clr),
      .en      (accept),
      .up      (core_result[i]),
      .nxt_pos (lane_pos[i]),
      .nxt_neg (lane_neg[i])
    );
  end

  // Majority with random tie-break for lanes whose vote is exactly balanced.
  always_comb begin
    thr = (lane_pos | (~lane_neg & tie_rand)) & ~lane_neg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      n         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      overrun   <= 1'b0;
    end else if (!run) begin
      state     <= ACCUM;
      n         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (store) begin
            if (last) begin
              out_valid <= 1'b1;
              out_data  <= thr;
              out_count <= sat_inc16(n);
              n         <= '0;
              state     <= HOLD;
            end else begin
              n <= sat_inc16(n);
            end
          end
        end
        HOLD: begin
          // The core cannot stall, so a store here is lost; record it rather than block.
          if (store) overrun <= 1'b1;
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_hv_bundle_counter.sv
module tb_hv_bundle_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       store;
  logic       last;
  logic [7:0] core_result;
  logic [7:0] tie_rand;
  logic       out_ready;

  logic       v8, v4;
  logic [7:0] d8, d4;
  logic [15:0] c8, c4;
  logic       ov8, ov4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hv_bundle_counter #(.DIM(7), .CW(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .run(run), .store(store), .last(last),
    .core_result(core_result), .tie_rand(tie_rand), .out_ready(out_ready),
    .out_valid(v8), .out_data(d8), .out_count(c8), .overrun(ov8)
  );

  hv_bundle_counter #(.DIM(7), .CW(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .run(run), .store(store), .last(last),
    .core_result(core_result), .tie_rand(tie_rand), .out_ready(out_ready),
    .out_valid(v4), .out_data(d4), .out_count(c4), .overrun(ov4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] v, input logic l);
    store = 1'b1; last = l; core_result = v;
    tick();
    store = 1'b0; last = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; store = 1'b0; last = 1'b0;
    core_result = '0; tie_rand = '0; out_ready = 1'b0;
    #3;
    chk("rst_valid", {31'd0, v8}, 32'd0);
    chk("rst_data", {24'd0, d8}, 32'd0);
    chk("rst_count", {16'd0, c8}, 32'd0);
    chk("rst_overrun", {31'd0, ov8}, 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // 1: plain majority, no ties on set lanes
    put(8'hF0, 1'b0);
    put(8'hCC, 1'b0);
    chk("t1_valid_early", {31'd0, v8}, 32'd0);
    put(8'hAA, 1'b1);
    chk("t1_valid", {31'd0, v8}, 32'd1);
    chk("t1_data", {24'd0, d8}, 32'hE8);
    chk("t1_count", {16'd0, c8}, 32'd3);
    handshake();
    chk("t1_valid_drop", {31'd0, v8}, 32'd0);

    // 2: every lane tied -> tie_rand selects
    put(8'hFF, 1'b0);
    tie_rand = 8'h5A;
    put(8'h00, 1'b1);
    tie_rand = 8'h00;
    chk("t2_data", {24'd0, d8}, 32'h5A);
    chk("t2_count", {16'd0, c8}, 32'd2);
    handshake();

    // 3: saturation; CW=4 lanes pin at 7, then step to 6 (still positive)
    for (int i = 0; i < 10; i++) put(8'hFF, 1'b0);
    put(8'h00, 1'b1);
    chk("t3_data_cw4", {24'd0, d4}, 32'hFF);
    chk("t3_count_cw4", {16'd0, c4}, 32'd11);
    chk("t3_data_cw8", {24'd0, d8}, 32'hFF);
    chk("t3_count_cw8", {16'd0, c8}, 32'd11);
    handshake();

    // 4: held result under backpressure, dropped store flags overrun
    put(8'hFF, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      if (k == 3) begin
        store = 1'b1; core_result = 8'h00;
      end
      tick();
      store = 1'b0;
      chk("t4_hold_valid", {31'd0, v8}, 32'd1);
      chk("t4_hold_data", {24'd0, d8}, 32'hFF);
      chk("t4_hold_count", {16'd0, c8}, 32'd1);
    end
    chk("t4_overrun", {31'd0, ov8}, 32'd1);
    handshake();
    chk("t4_valid_drop", {31'd0, v8}, 32'd0);
    put(8'h0F, 1'b1);
    chk("t4_data", {24'd0, d8}, 32'h0F);
    chk("t4_count", {16'd0, c8}, 32'd1);
    handshake();

    // 5: run=0 discards partial bundle and clears overrun
    put(8'hFF, 1'b0);
    put(8'hFF, 1'b0);
    run = 1'b0;
    tick();
    run = 1'b1;
    chk("t5_clr_valid", {31'd0, v8}, 32'd0);
    chk("t5_clr_data", {24'd0, d8}, 32'd0);
    put(8'h0F, 1'b1);
    chk("t5_data", {24'd0, d8}, 32'h0F);
    chk("t5_count", {16'd0, c8}, 32'd1);
    chk("t5_overrun", {31'd0, ov8}, 32'd0);

    // 6: async reset while holding a result
    chk("t6_pre_valid", {31'd0, v8}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'd0, v8}, 32'd0);
    chk("t6_async_count", {16'd0, c8}, 32'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("t6_post_valid", {31'd0, v8}, 32'd0);
    chk("t6_post_count", {16'd0, c8}, 32'd0);
    put(8'h3C, 1'b1);
    chk("t6_accum_data", {24'd0, d8}, 32'h3C);
    chk("t6_accum_count", {16'd0, c8}, 32'd1);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
